decode_stage: RTL and testbench

RV32I instruction decode and ID/EX pipeline register. It sits between instruction fetch and execute, and is the direct consumer of the register file. The block drives rs1/rs2 read addresses combinationally from the incoming instruction and decodes control fields and immediates. It captures operands and controls into the ID/EX register under a valid/ready handshake, with a load-use interlock and flush.

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/instr_decoder.sv | 98 +++++++++
 rtl/decode_stage.sv | 135 +++++++++++++
 tb/tb_decode_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared RV32I opcodes, ALU op and immediate-format types
package cpu_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // alt selects SUB on funct3=000 and SRA on funct3=101
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational RV32I decode of controls, immediate and source use
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [4:0]  rd_o,
    output logic [2:0]  funct3_o,
    output logic [31:0] imm_o,
    output logic [3:0]  alu_op_o,
    output logic        alu_src_imm_o,
    output logic        alu_src_pc_o,
    output logic        reg_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        branch_o,
    output logic        jump_o,
    output logic        illegal_o,
    output logic        use_rs1_o,
    output logic        use_rs2_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    imm_fmt_e   fmt;
    alu_op_e    alu;
    logic       rw;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign rd_o     = instr_i[11:7];
    assign funct3_o = funct3;
    assign alu_op_o = alu;

    always_comb begin
        fmt           = IMM_NONE;
        alu           = ALU_ADD;
        alu_src_imm_o = 1'b0;
        alu_src_pc_o  = 1'b0;
        rw            = 1'b0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        branch_o      = 1'b0;
        jump_o        = 1'b0;
        illegal_o     = 1'b0;
        use_rs1_o     = 1'b1;
        use_rs2_o     = 1'b0;
        case (opcode)
            OPC_LUI: begin
                fmt = IMM_U; alu = ALU_PASSB; alu_src_imm_o = 1'b1; rw = 1'b1; use_rs1_o = 1'b0;
            end
            OPC_AUIPC: begin
                fmt = IMM_U; alu_src_imm_o = 1'b1; alu_src_pc_o = 1'b1; rw = 1'b1; use_rs1_o = 1'b0;
            end
            OPC_JAL: begin
                fmt = IMM_J; alu_src_imm_o = 1'b1; alu_src_pc_o = 1'b1; jump_o = 1'b1;
                rw = 1'b1; use_rs1_o = 1'b0;
            end
            OPC_JALR: begin
                fmt = IMM_I; alu_src_imm_o = 1'b1; jump_o = 1'b1; rw = 1'b1;
            end
            // ALU computes the branch target; the compare itself happens in EX
            OPC_BRANCH: begin
                fmt = IMM_B; alu_src_imm_o = 1'b1; alu_src_pc_o = 1'b1; branch_o = 1'b1;
                use_rs2_o = 1'b1;
            end
            OPC_LOAD: begin
                fmt = IMM_I; alu_src_imm_o = 1'b1; mem_read_o = 1'b1; rw = 1'b1;
            end
            OPC_STORE: begin
                fmt = IMM_S; alu_src_imm_o = 1'b1; mem_write_o = 1'b1; use_rs2_o = 1'b1;
            end
            OPC_OP_IMM: begin
                fmt = IMM_I; alu_src_imm_o = 1'b1; rw = 1'b1;
                alu = alu_from_funct3(funct3, (funct3 == 3'b101) && instr_i[30]);
            end
            OPC_OP: begin
                alu = alu_from_funct3(funct3, instr_i[30]); rw = 1'b1; use_rs2_o = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
        reg_write_o = rw && (instr_i[11:7] != 5'd0);
    end

    always_comb begin
        imm_o = 32'd0;
        case (fmt)
            IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
            IMM_U:   imm_o = {instr_i[31:12], 12'd0};
            IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            default: imm_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode with ID/EX register, load-use interlock and flush
module decode_stage
    import cpu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_valid,
    output logic                   if_ready,
    input  logic [31:0]            if_instr,
    input  logic [XLEN-1:0]        if_pc,
    output logic [4:0]             rs1_addr,
    output logic [4:0]             rs2_addr,
    input  logic [XLEN-1:0]        rs1_data,
    input  logic [XLEN-1:0]        rs2_data,
    input  logic                   flush,
    input  logic                   ex_ready,
    output logic                   ex_valid,
    output logic [XLEN-1:0]        ex_pc,
    output logic [XLEN-1:0]        ex_rs1_data,
    output logic [XLEN-1:0]        ex_rs2_data,
    output logic [XLEN-1:0]        ex_imm,
    output logic [4:0]             ex_rd,
    output logic [3:0]             ex_alu_op,
    output logic                   ex_alu_src_imm,
    output logic                   ex_alu_src_pc,
    output logic                   ex_reg_write,
    output logic                   ex_mem_read,
    output logic                   ex_mem_write,
    output logic                   ex_branch,
    output logic                   ex_jump,
    output logic                   ex_illegal,
    output logic [2:0]             ex_funct3,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [4:0]  dec_rd;
    logic [2:0]  dec_funct3;
    logic [31:0] dec_imm;
    logic [3:0]  dec_alu_op;
    logic [7:0]  dec_ctrl;
    logic        dec_use_rs1, dec_use_rs2;

    logic                   ex_valid_q;
    logic [XLEN-1:0]        ex_pc_q, ex_rs1_q, ex_rs2_q, ex_imm_q;
    logic [4:0]             ex_rd_q;
    logic [3:0]             ex_alu_op_q;
    logic [2:0]             ex_funct3_q;
    logic [7:0]             ex_ctrl_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   hazard, accept;

    instr_decoder u_dec (
        .instr_i       (if_instr),
        .rd_o          (dec_rd),
        .funct3_o      (dec_funct3),
        .imm_o         (dec_imm),
        .alu_op_o      (dec_alu_op),
        .alu_src_imm_o (dec_ctrl[7]),
        .alu_src_pc_o  (dec_ctrl[6]),
        .reg_write_o   (dec_ctrl[5]),
        .mem_read_o    (dec_ctrl[4]),
        .mem_write_o   (dec_ctrl[3]),
        .branch_o      (dec_ctrl[2]),
        .jump_o        (dec_ctrl[1]),
        .illegal_o     (dec_ctrl[0]),
        .use_rs1_o     (dec_use_rs1),
        .use_rs2_o     (dec_use_rs2)
    );

    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];

    // A load in ID/EX whose rd feeds the incoming instruction must leave before it is read
    assign hazard = if_valid && ex_valid_q && ex_ctrl_q[4] && (ex_rd_q != 5'd0) &&
                    ((dec_use_rs1 && (rs1_addr == ex_rd_q)) ||
                     (dec_use_rs2 && (rs2_addr == ex_rd_q)));
    assign accept   = !hazard && (!ex_valid_q || ex_ready);
    assign if_ready = accept;

    assign stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_pc_q     <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_imm_q    <= '0;
            ex_rd_q     <= '0;
            ex_alu_op_q <= ALU_ADD;
            ex_funct3_q <= '0;
            ex_ctrl_q   <= '0;
            stall_cnt_q <= '0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (if_valid && accept) begin
            ex_valid_q  <= 1'b1;
            ex_pc_q     <= if_pc;
            ex_rs1_q    <= rs1_data;
            ex_rs2_q    <= rs2_data;
            ex_imm_q    <= dec_imm;
            ex_rd_q     <= dec_rd;
            ex_alu_op_q <= dec_alu_op;
            ex_funct3_q <= dec_funct3;
            ex_ctrl_q   <= dec_ctrl;
        end else if (hazard && ex_ready) begin
            ex_valid_q  <= 1'b0;
            stall_cnt_q <= stall_cnt_d;
        end else if (ex_valid_q && ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_pc          = ex_pc_q;
    assign ex_rs1_data    = ex_rs1_q;
    assign ex_rs2_data    = ex_rs2_q;
    assign ex_imm         = ex_imm_q;
    assign ex_rd          = ex_rd_q;
    assign ex_alu_op      = ex_alu_op_q;
    assign ex_funct3      = ex_funct3_q;
    assign ex_alu_src_imm = ex_ctrl_q[7];
    assign ex_alu_src_pc  = ex_ctrl_q[6];
    assign ex_reg_write   = ex_ctrl_q[5];
    assign ex_mem_read    = ex_ctrl_q[4];
    assign ex_mem_write   = ex_ctrl_q[3];
    assign ex_branch      = ex_ctrl_q[2];
    assign ex_jump        = ex_ctrl_q[1];
    assign ex_illegal     = ex_ctrl_q[0];
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized scoreboard bench for decode_stage
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [7:0]  flags;
    } exp_t;
    typedef logic [$bits(exp_t)-1:0] wide_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0, flush = 1'b0, ex_ready = 1'b0;
    logic [31:0] if_instr = '0, if_pc = '0, rs1_data = '0, rs2_data = '0;
    logic        if_ready, ex_valid;
    logic [4:0]  rs1_addr, rs2_addr, ex_rd;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [3:0]  ex_alu_op;
    logic [2:0]  ex_funct3;
    logic        ex_alu_src_imm, ex_alu_src_pc, ex_reg_write, ex_mem_read;
    logic        ex_mem_write, ex_branch, ex_jump, ex_illegal;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
        .ex_alu_src_imm(ex_alu_src_imm), .ex_alu_src_pc(ex_alu_src_pc),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal),
        .ex_funct3(ex_funct3), .stall_cnt(stall_cnt)
    );

    exp_t dut_view;
    assign dut_view = {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_alu_op, ex_funct3,
                       {ex_alu_src_imm, ex_alu_src_pc, ex_reg_write, ex_mem_read,
                        ex_mem_write, ex_branch, ex_jump, ex_illegal}};

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        q[$];
    bit          m_valid = 1'b0;
    bit          m_load = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [15:0] m_stall = '0;
    int          alu_base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    logic [6:0]  ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};

    task automatic check(input string name, input wide_t act, input wide_t req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference decode straight from the RV32I field definitions
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2,
                                        output bit u1, output bit u2);
        exp_t        e;
        logic [31:0] sgn, i_imm, s_imm, b_imm, u_imm, j_imm;
        logic [6:0]  op;
        int          alu;
        bit          sim, spc, rw, mr, mw, br, jp, ill;
        op    = ins[6:0];
        sgn   = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        i_imm = $signed(ins) >>> 20;
        s_imm = (i_imm & ~32'h1F) | ((ins >> 7) & 32'h1F);
        b_imm = (sgn & 32'hFFFF_F000) | (((ins >> 7) & 32'h1) << 11) |
                (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
        u_imm = ins & 32'hFFFF_F000;
        j_imm = (sgn & 32'hFFF0_0000) | (ins & 32'h000F_F000) |
                (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
        {sim, spc, rw, mr, mw, br, jp, ill} = 8'h0;
        u1 = 1'b1; u2 = 1'b0; alu = 0;
        e.imm = 32'h0;
        case (op)
            7'h37: begin e.imm = u_imm; alu = 10; sim = 1; rw = 1; u1 = 0; end
            7'h17: begin e.imm = u_imm; sim = 1; spc = 1; rw = 1; u1 = 0; end
            7'h6F: begin e.imm = j_imm; sim = 1; spc = 1; jp = 1; rw = 1; u1 = 0; end
            7'h67: begin e.imm = i_imm; sim = 1; jp = 1; rw = 1; end
            7'h63: begin e.imm = b_imm; sim = 1; spc = 1; br = 1; u2 = 1; end
            7'h03: begin e.imm = i_imm; sim = 1; mr = 1; rw = 1; end
            7'h23: begin e.imm = s_imm; sim = 1; mw = 1; u2 = 1; end
            7'h13: begin
                e.imm = i_imm; sim = 1; rw = 1; alu = alu_base[ins[14:12]];
                if (ins[14:12] == 3'd5 && ins[30]) alu = 7;
            end
            7'h33: begin
                rw = 1; u2 = 1; alu = alu_base[ins[14:12]];
                if (ins[14:12] == 3'd0 && ins[30]) alu = 1;
                if (ins[14:12] == 3'd5 && ins[30]) alu = 7;
            end
            default: ill = 1;
        endcase
        if (ins[11:7] == 5'd0) rw = 0;
        e.pc = pc; e.r1 = r1; e.r2 = r2;
        e.rd = ins[11:7]; e.f3 = ins[14:12]; e.alu = 4'(alu);
        e.flags = {sim, spc, rw, mr, mw, br, jp, ill};
        return e;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_load = 1'b0; m_rd = '0; m_stall = '0;
        q.delete();
    endtask

    // One cycle: drive at negedge, check against the model, advance the model
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit rdy, input bit fl);
        exp_t e;
        bit   u1, u2, hz, rexp;
        @(negedge clk);
        if_valid = v; if_instr = ins; if_pc = pc; ex_ready = rdy; flush = fl;
        rs1_data = $urandom; rs2_data = $urandom;
        #1;
        e = ref_decode(ins, pc, rs1_data, rs2_data, u1, u2);
        hz = v && m_valid && m_load && (m_rd != 5'd0) &&
             ((u1 && ins[19:15] == m_rd) || (u2 && ins[24:20] == m_rd));
        rexp = !hz && (!m_valid || rdy);
        check("if_ready", wide_t'(if_ready), wide_t'(rexp));
        check("ex_valid", wide_t'(ex_valid), wide_t'(m_valid));
        check("stall_cnt", wide_t'(stall_cnt), wide_t'(m_stall));
        check("rs_addr", wide_t'({rs1_addr, rs2_addr}), wide_t'({ins[19:15], ins[24:20]}));
        if (m_valid) begin
            if (q.size() == 0) check("held_missing", wide_t'(0), wide_t'(1));
            else check("held_entry", dut_view, q[0]);
        end
        if (fl) begin
            if (m_valid && q.size() > 0) void'(q.pop_back());
            m_valid = 1'b0;
        end else if (v && rexp) begin
            q.push_back(e);
            m_valid = 1'b1; m_load = e.flags[4]; m_rd = e.rd;
        end else if (hz && rdy) begin
            m_valid = 1'b0;
            if (m_stall != 16'hFFFF) m_stall++;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
    endtask

    // Scoreboard monitor: retire an entry whenever execute takes it
    always @(negedge clk) begin
        #3;
        if (rst_n && ex_valid && ex_ready && !flush) begin
            if (q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL retire: got unexpected entry %h expected none", dut_view);
            end else begin
                check("retire", dut_view, q.pop_front());
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins        = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 9)];
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    initial begin
        logic [31:0] pc;
        pc = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_view", dut_view, wide_t'(0));
        check("reset_valid", wide_t'(ex_valid), wide_t'(0));
        check("reset_stall", wide_t'(stall_cnt), wide_t'(0));
        check("reset_if_ready", wide_t'(if_ready), wide_t'(1));
        #1 rst_n = 1'b1;

        step(1, 32'h00500093, 32'h0, 1, 0);
        #2;
        check("addi_valid", wide_t'(ex_valid), wide_t'(1));
        check("addi_imm", wide_t'(ex_imm), wide_t'(32'd5));
        check("addi_rd", wide_t'(ex_rd), wide_t'(5'd1));
        check("addi_ctrl", wide_t'({ex_alu_op, ex_alu_src_imm, ex_reg_write}), wide_t'(6'b0000_11));

        step(1, 32'h00012283, 32'h4, 1, 0);
        step(1, 32'h00128333, 32'h8, 1, 0);
        #2;
        check("bubble_valid", wide_t'(ex_valid), wide_t'(0));
        check("bubble_stall", wide_t'(stall_cnt), wide_t'(1));
        step(1, 32'h00128333, 32'h8, 1, 0);
        #2;
        check("dep_issue", wide_t'({ex_valid, ex_rd, ex_alu_op}), wide_t'({1'b1, 5'd6, 4'd0}));

        step(1, 32'h00012003, 32'hC, 1, 0);
        step(1, 32'h00100333, 32'h10, 1, 0);
        #2;
        check("x0_no_stall", wide_t'({ex_valid, ex_rd, stall_cnt}), wide_t'({1'b1, 5'd6, 16'd1}));

        step(1, 32'h00500093, 32'h100, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h00208133, 32'h104, 0, 0);
            #2;
            check("bp_hold_pc", wide_t'(ex_pc), wide_t'(32'h100));
        end
        step(1, 32'h00208133, 32'h104, 1, 0);
        #2;
        check("bp_release_pc", wide_t'(ex_pc), wide_t'(32'h104));

        step(1, 32'h00012283, 32'h200, 1, 0);
        step(1, 32'h00128333, 32'h204, 1, 1);
        #2;
        check("flush_valid", wide_t'(ex_valid), wide_t'(0));
        check("flush_stall", wide_t'(stall_cnt), wide_t'(1));
        step(0, 32'h0, 32'h0, 1, 0);

        step(1, 32'h0000057F, 32'h300, 1, 0);
        #2;
        check("illegal", wide_t'({ex_illegal, ex_reg_write, ex_mem_write, ex_mem_read}),
              wide_t'(4'b1000));

        step(1, 32'h00500093, 32'h400, 1, 0);
        #2;
        check("pre_reset_valid", wide_t'(ex_valid), wide_t'(1));
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_valid", wide_t'(ex_valid), wide_t'(0));
        check("async_reset_view", dut_view, wide_t'(0));
        check("async_reset_stall", wide_t'(stall_cnt), wide_t'(0));
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;

        pc = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 8, rand_instr(), pc,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
            pc += 4;
        end
        repeat (3) step(0, 32'h0, 32'h0, 1, 0);
        check("queue_drained", wide_t'(q.size()), wide_t'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
